// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg -- shared definitions for the fetch-side next-PC logic.
//   state_e          : next_pc_unit control states (BOOT, RUN, FAULT)
//   PC_RESET_DEFAULT : default fetch address after reset
//   INSTR_BYTES      : sequential fetch stride
//   CNT_W            : width of the branch statistics counters
//   sat_inc()        : saturating increment for the statistics counters
// ---------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    localparam logic [63:0] PC_RESET_DEFAULT = 64'h0;
    localparam int          INSTR_BYTES      = 4;
    localparam int          CNT_W            = 32;

    // Counters stick at all-ones instead of rolling back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/branch_target_adder.sv
// ---------------------------------------------------------------------------
// branch_target_adder -- B-type branch target and alignment check.
//   ex_pc_i   : PC of the branch in EX
//   imm_i     : sign-extended B-type immediate, not yet shifted
//   target_o  : ex_pc_i + (imm_i << 1), wrapping modulo 2^64
//   aligned_o : target is a legal 4-byte fetch address
// ---------------------------------------------------------------------------
module branch_target_adder (
    input  logic [63:0] ex_pc_i,
    input  logic [63:0] imm_i,
    output logic [63:0] target_o,
    output logic        aligned_o
);

    // B-type immediates encode half-word offsets; the top immediate bit
    // falls off, which is the same as doing the shift modulo 2^64.
    assign target_o  = ex_pc_i + {imm_i[62:0], 1'b0};
    assign aligned_o = (target_o[1:0] == 2'b00);

endmodule

// File: rtl/next_pc_unit.sv
// ---------------------------------------------------------------------------
// next_pc_unit -- fetch address generator with branch redirect.
//   clk, reset          : clock, synchronous active-high reset
//   stall               : hazard unit holds the PC
//   branch_ex           : EX-stage instruction is a conditional branch
//   addermuxselect      : branch comparator says taken
//   ex_pc, imm_ex       : branch PC and unshifted B-type immediate
//   pc, pc_valid        : current fetch address and its valid
//   flush               : kill IF/ID and ID/EX at the coming edge
//   misaligned          : sticky fault, set by a taken misaligned target
//   branch_count        : branches resolved in RUN (saturating)
//   taken_count         : valid redirects (saturating)
// ---------------------------------------------------------------------------
module next_pc_unit
    import riscv_pkg::*;
#(
    parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_ex,
    input  logic             addermuxselect,
    input  logic [63:0]      ex_pc,
    input  logic [63:0]      imm_ex,
    output logic [63:0]      pc,
    output logic             pc_valid,
    output logic             flush,
    output logic             misaligned,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    state_e           state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;

    logic [63:0] target;
    logic        aligned;
    logic        take;
    logic        redirect;

    branch_target_adder u_bta (
        .ex_pc_i   (ex_pc),
        .imm_i     (imm_ex),
        .target_o  (target),
        .aligned_o (aligned)
    );

    assign take     = branch_ex & addermuxselect & (state_q == ST_RUN);
    assign redirect = take & aligned;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mis_d   = mis_q;
        bcnt_d  = bcnt_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (branch_ex) bcnt_d = sat_inc(bcnt_q);
                // A redirect wins over stall: the stalled fetch is flushed anyway.
                if (take) begin
                    if (aligned) begin
                        pc_d   = target;
                        tcnt_d = sat_inc(tcnt_q);
                    end else begin
                        mis_d   = 1'b1;
                        state_d = ST_FAULT;
                    end
                end else if (!stall) begin
                    pc_d = pc_q + 64'(INSTR_BYTES);
                end
            end
            // FAULT (and the unused encoding) hold everything until reset.
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= PC_RESET;
            mis_q   <= 1'b0;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign pc           = pc_q;
    assign pc_valid     = (state_q == ST_RUN) & ~reset;
    assign flush        = redirect & ~reset;
    assign misaligned   = mis_q;
    assign branch_count = bcnt_q;
    assign taken_count  = tcnt_q;

endmodule

// File: tb/tb_next_pc_unit.sv
module tb_next_pc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, branch_ex, addermuxselect;
    logic [63:0] ex_pc, imm_ex;
    logic [63:0] pc;
    logic        pc_valid, flush, misaligned;
    logic [31:0] branch_count, taken_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    next_pc_unit #(.PC_RESET(64'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_ex      (branch_ex),
        .addermuxselect (addermuxselect),
        .ex_pc          (ex_pc),
        .imm_ex         (imm_ex),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .flush          (flush),
        .misaligned     (misaligned),
        .branch_count   (branch_count),
        .taken_count    (taken_count)
    );

    // Inputs applied during one cycle and the outputs expected in that cycle.
    typedef struct {
        logic        rst, stl, br, ams;
        logic [63:0] ex, imm;
        logic [63:0] e_pc;
        logic        e_vld, e_fl, e_mis;
        logic [31:0] e_bc, e_tc;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs[NV];

    function automatic vec_t mkv(
        input logic rst, input logic stl, input logic br, input logic ams,
        input logic [63:0] ex, input logic [63:0] imm, input logic [63:0] e_pc,
        input logic e_vld, input logic e_fl, input logic e_mis,
        input logic [31:0] e_bc, input logic [31:0] e_tc);
        vec_t v;
        v.rst = rst; v.stl = stl; v.br = br; v.ams = ams;
        v.ex = ex; v.imm = imm; v.e_pc = e_pc;
        v.e_vld = e_vld; v.e_fl = e_fl; v.e_mis = e_mis;
        v.e_bc = e_bc; v.e_tc = e_tc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset          = v.rst;
        stall          = v.stl;
        branch_ex      = v.br;
        addermuxselect = v.ams;
        ex_pc          = v.ex;
        imm_ex         = v.imm;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d.pc", i),         pc,                   v.e_pc);
        chk($sformatf("v%0d.pc_valid", i),   {63'b0, pc_valid},    {63'b0, v.e_vld});
        chk($sformatf("v%0d.flush", i),      {63'b0, flush},       {63'b0, v.e_fl});
        chk($sformatf("v%0d.misaligned", i), {63'b0, misaligned},  {63'b0, v.e_mis});
        chk($sformatf("v%0d.branch_cnt", i), {32'b0, branch_count}, {32'b0, v.e_bc});
        chk($sformatf("v%0d.taken_cnt", i),  {32'b0, taken_count},  {32'b0, v.e_tc});
    endtask

    localparam logic [63:0] NEG2  = 64'hFFFF_FFFF_FFFF_FFFE;
    localparam logic [63:0] HIGH  = 64'hFFFF_FFFF_FFFF_FFF0;
    localparam logic [63:0] TOP   = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        //                 rst   stl   br    ams   ex_pc   imm     pc     vld   fl    mis   bc     tc
        // reset with a branch presented: no flush, no valid
        vecs[0]  = mkv(1'b1, 1'b0, 1'b1, 1'b1, 64'h40, 64'h10, 64'h0,  1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        // release: BOOT then RUN, pc 0,0,4,8
        vecs[1]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,  64'h0,  1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        vecs[2]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,  64'h0,  1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        vecs[3]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,  64'h4,  1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        // stall three cycles at 0x8, then resume to 0xC
        vecs[4]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  64'h0,  64'h8,  1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        vecs[5]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  64'h0,  64'h8,  1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        vecs[6]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  64'h0,  64'h8,  1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        vecs[7]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,  64'h8,  1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        vecs[8]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,  64'hC,  1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        // taken 0x40 + (0x10<<1) = 0x60
        vecs[9]  = mkv(1'b0, 1'b0, 1'b1, 1'b1, 64'h40, 64'h10, 64'h10, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        // not-taken branch: counted, no redirect
        vecs[10] = mkv(1'b0, 1'b0, 1'b1, 1'b0, 64'h0,  64'h0,  64'h60, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1);
        // stall + taken 0x100 + (-2<<1) = 0xFC: redirect wins
        vecs[11] = mkv(1'b0, 1'b1, 1'b1, 1'b1, 64'h100, NEG2,  64'h64, 1'b1, 1'b1, 1'b0, 32'd2, 32'd1);
        vecs[12] = mkv(1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  64'h0,  64'hFC, 1'b1, 1'b0, 1'b0, 32'd3, 32'd2);
        // taken to 0x42: misaligned, pc held, FAULT
        vecs[13] = mkv(1'b0, 1'b0, 1'b1, 1'b1, 64'h40, 64'h1,  64'hFC, 1'b1, 1'b0, 1'b0, 32'd3, 32'd2);
        vecs[14] = mkv(1'b0, 1'b0, 1'b1, 1'b1, 64'h40, 64'h10, 64'hFC, 1'b0, 1'b0, 1'b1, 32'd4, 32'd2);
        vecs[15] = mkv(1'b0, 1'b0, 1'b1, 1'b1, 64'h40, 64'h10, 64'hFC, 1'b0, 1'b0, 1'b1, 32'd4, 32'd2);
        vecs[16] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,  64'hFC, 1'b0, 1'b0, 1'b1, 32'd4, 32'd2);
        // reset leaves FAULT
        vecs[17] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,  64'hFC, 1'b0, 1'b0, 1'b1, 32'd4, 32'd2);
        vecs[18] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,  64'h0,  1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        vecs[19] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,  64'h0,  1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        // jump to the top word (0x..F0 + 0xC), then wrap to 0
        vecs[20] = mkv(1'b0, 1'b0, 1'b1, 1'b1, HIGH,   64'h6,  64'h4,  1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        vecs[21] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,  TOP,    1'b1, 1'b0, 1'b0, 32'd1, 32'd1);
        vecs[22] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,  64'h0,  1'b1, 1'b0, 1'b0, 32'd1, 32'd1);
        // reset in the same cycle as a take
        vecs[23] = mkv(1'b1, 1'b0, 1'b1, 1'b1, 64'h40, 64'h10, 64'h4,  1'b0, 1'b0, 1'b0, 32'd1, 32'd1);
        vecs[24] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,  64'h0,  1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        vecs[25] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,  64'h0,  1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Establish a known state before the table starts.
        reset = 1'b1; stall = 1'b0; branch_ex = 1'b0; addermuxselect = 1'b0;
        ex_pc = '0; imm_ex = '0;
        @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            #1 drive(vecs[i]);
            @(negedge clk);
            check_vec(i, vecs[i]);
            @(posedge clk);
        end

        // Hand sequence: a taken branch presented in BOOT is ignored.
        #1 reset = 1'b1; branch_ex = 1'b0; addermuxselect = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0; branch_ex = 1'b1; addermuxselect = 1'b1;
        ex_pc = 64'h40; imm_ex = 64'h10;
        @(negedge clk);
        chk("boot.flush", {63'b0, flush}, 64'h0);
        chk("boot.pc_valid", {63'b0, pc_valid}, 64'h0);
        @(posedge clk);
        #1 branch_ex = 1'b0; addermuxselect = 1'b0;
        @(negedge clk);
        chk("boot.pc_held", pc, 64'h0);
        chk("boot.branch_cnt", {32'b0, branch_count}, 64'h0);
        chk("boot.taken_cnt", {32'b0, taken_count}, 64'h0);
        chk("boot.run_valid", {63'b0, pc_valid}, 64'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("boot.first_step", pc, 64'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 SHALL expose parameter PC_RESET, default 64'h0, meaning the PC value loaded on reset.
REQ-002 SHALL expose port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL expose port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL expose port stall, input, 1, hazard unit request to hold the PC.
REQ-005 SHALL expose port branch_ex, input, 1, EX-stage instruction is a conditional branch.
REQ-006 SHALL expose port addermuxselect, input, 1, branch comparator result, taken when 1.
REQ-007 SHALL expose port ex_pc, input, 64, PC of the EX-stage instruction.
REQ-008 SHALL expose port imm_ex, input, 64, sign-extended B-type immediate, unshifted.
REQ-009 SHALL expose port pc, output, 64, current fetch address.
REQ-010 SHALL expose port pc_valid, output, 1, fetch address valid.
REQ-011 SHALL expose port flush, output, 1, kill IF/ID and ID/EX at the coming edge.
REQ-012 SHALL expose port misaligned, output, 1, sticky misaligned-target fault.
REQ-013 SHALL expose port branch_count, output, 32, resolved-branch counter.
REQ-014 SHALL expose port taken_count, output, 32, taken-branch counter.

Function
REQ-015 SHALL implement states BOOT, RUN and FAULT.
REQ-016 SHALL leave BOOT for RUN after exactly one cycle, with pc_valid=0 in BOOT and pc_valid=1 in RUN.
REQ-017 SHALL compute target = ex_pc + (imm_ex << 1), modulo 2^64, with wrap-around ignored.
REQ-018 SHALL define take = branch_ex & addermuxselect & (state==RUN).
REQ-019 SHALL, when take and target[1:0]==2'b00, load pc<=target at the edge and drive flush=1 combinationally in that cycle.
REQ-020 SHALL, when take and target[1:0]!=2'b00, hold pc, keep flush=0, set misaligned<=1 and go to FAULT.
REQ-021 SHALL, in RUN without take and with stall=1, hold pc.
REQ-022 SHALL, in RUN without take and with stall=0, load pc<=pc+4.
REQ-023 SHALL give a valid redirect priority over stall, with flush=1 even when stall=1.
REQ-024 SHALL, in FAULT, hold pc, drive pc_valid=0 and flush=0, and ignore all inputs until reset.
REQ-025 SHALL, in BOOT, hold pc and ignore branch_ex.
REQ-026 SHALL increment branch_count on each cycle with branch_ex=1 in RUN, saturating at 32'hFFFF_FFFF.
REQ-027 SHALL increment taken_count on each valid redirect, saturating at 32'hFFFF_FFFF.
REQ-028 SHALL count a misaligned take in branch_count but not in taken_count.
REQ-029 SHALL hold pc+4 wrap at 64'hFFFF_FFFF_FFFF_FFFC to 64'h0 without a fault.

Reset
REQ-030 SHALL, on reset=1 at an edge, set pc=PC_RESET, state=BOOT, misaligned=0 and both counters to 0.
REQ-031 SHALL give reset priority over stall, take and FAULT, including a reset asserted in the same cycle as a take.
REQ-032 SHALL hold pc_valid=0 and flush=0 while reset is asserted.

Structure
REQ-033 SHALL place the state enum, PC_RESET default, INSTR_BYTES=4 and the counter width in shared package riscv_pkg.
REQ-034 SHALL instantiate one sub-module, branch_target_adder, which performs the 64-bit ex_pc+(imm<<1) and the alignment check.

Verification
REQ-035 SHALL cover reset release with PC_RESET=0 and no stall: pc reads 0,0,4,8; pc_valid reads 0,1,1,1.
REQ-036 SHALL cover a taken branch with ex_pc=0x40 and imm_ex=0x10: flush=1 for one cycle, next pc=0x60, taken_count=1.
REQ-037 SHALL cover stall=1 for 3 cycles at pc=0x8: pc holds 0x8, then resumes at 0xC.
REQ-038 SHALL cover stall=1 together with a taken branch (ex_pc=0x100, imm_ex=-2): pc=0xFC, flush=1.
REQ-039 SHALL cover a target of 0x42: misaligned=1 and pc held, with no further change under later branches until reset clears it.
REQ-040 SHALL cover pc=0xFFFF_FFFF_FFFF_FFFC with no stall: next pc=0, and a reset asserted in the same cycle as a take yields pc=PC_RESET with counters at 0.
